// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : One requester port of the data-memory arbiter. The master
//                modport is the requester side; the slave modport is the
//                arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int ALEN = 32,
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [3:0]      be;
   logic [2:0]      funct3;
   logic [ALEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic            lock;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, be, funct3, addr, wdata, lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, be, funct3, addr, wdata, lock,
      output gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single data-memory port between the core MEM
//                stage (port 0) and a loader/debug master (port 1).
//                Fixed priority to port 0, starvation override for port 1,
//                atomic lock, and routing of 1-cycle-latency read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ALEN       = 32,
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   dmem_arbiter_if.slave        p0,
   dmem_arbiter_if.slave        p1,
   output logic                 mem_we,
   output logic [3:0]           mem_be,
   output logic [2:0]           mem_funct3,
   output logic [ALEN-1:0]      mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   input  wire logic [XLEN-1:0] mem_rdata
);

   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   localparam logic [1:0] UNLOCKED = 2'd0;
   localparam logic [1:0] LOCKED0  = 2'd1;
   localparam logic [1:0] LOCKED1  = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       gnt0;
   logic       gnt1;
   logic [3:0] starve_cnt;
   logic       rd_pending;
   logic       rd_owner;

   // Lock FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= UNLOCKED;
      else     state <= state_nxt;
   end

   // Lock FSM next state: a locked port releases as soon as it drops lock,
   // whether or not it is requesting (a requesting release is still granted)
   always_comb begin
      state_nxt = state;
      case (state)
         UNLOCKED: begin
            if (gnt0 && p0.lock)      state_nxt = LOCKED0;
            else if (gnt1 && p1.lock) state_nxt = LOCKED1;
         end
         LOCKED0:  if (!p0.lock) state_nxt = UNLOCKED;
         LOCKED1:  if (!p1.lock) state_nxt = UNLOCKED;
         default:  state_nxt = UNLOCKED;
      endcase
   end

   // Lock FSM outputs: grant decision, lock owner first, then starvation
   // override, then fixed priority to port 0; nothing granted in reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (state == LOCKED0)                           gnt0 = p0.req;
         else if (state == LOCKED1)                      gnt1 = p1.req;
         else if ((starve_cnt == STARVE_LIM) && p1.req) gnt1 = 1'b1;
         else if (p0.req)                                gnt0 = 1'b1;
         else if (p1.req)                                gnt1 = 1'b1;
      end
   end

   assign p0.gnt = gnt0;
   assign p1.gnt = gnt1;

   // Memory-side mux: idle bus presents a harmless word read of address 0
   always_comb begin
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_funct3 = F3_WORD;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (gnt0) begin
         mem_we     = p0.we;
         mem_be     = p0.be;
         mem_funct3 = p0.funct3;
         mem_addr   = p0.addr;
         mem_wdata  = p0.wdata;
      end else if (gnt1) begin
         mem_we     = p1.we;
         mem_be     = p1.be;
         mem_funct3 = p1.funct3;
         mem_addr   = p1.addr;
         mem_wdata  = p1.wdata;
      end
   end

   // Starvation counter: frozen while locked, cleared whenever port 1 is
   // served or stops asking, saturating at the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (state == UNLOCKED) begin
         if (gnt1 || !p1.req)
            starve_cnt <= 4'd0;
         else if (gnt0 && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Read tracking: remember which port owns the load whose data the
   // memory returns on the following cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pending <= (gnt0 && !p0.we) || (gnt1 && !p1.we);
         rd_owner   <= gnt1;
      end
   end

   assign p0.rvalid = rd_pending && !rd_owner;
   assign p1.rvalid = rd_pending &&  rd_owner;
   assign p0.rdata  = p0.rvalid ? mem_rdata : '0;
   assign p1.rdata  = p1.rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory port (RAM plus MMIO LED/tohost) between the CPU core's MEM stage (port 0) and a program loader/debug master (port 1). It accepts one access per cycle and issues it to data memory, tracks which port owns each in-flight read across the memory's 1-cycle read latency, and routes the returned word back. Arbitration is fixed-priority to the core, with a starvation counter and an atomic lock.

## Interface

Parameters:
- ALEN, riscv_pkg ALEN: address width.
- XLEN, riscv_pkg XLEN: data width.
- STARVE_MAX, 4: consecutive port-0 grants made while port 1 waits, after which port 1 is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pN_req  in  1  access request (N = 0 core, 1 loader)
- pN_we  in  1  1 = store, 0 = load
- pN_be  in  4  store byte enables
- pN_funct3  in  3  load/store type (F3_BYTE..F3_LHU)
- pN_addr  in  ALEN  byte address
- pN_wdata  in  XLEN  store data
- pN_lock  in  1  hold ownership after this grant
- pN_gnt  out  1  access accepted this cycle (combinational)
- pN_rvalid  out  1  load data valid (registered)
- pN_rdata  out  XLEN  load data, valid only with pN_rvalid
- mem_we  out  1  to DataMemory MemWrite
- mem_be  out  4  to DataMemory be
- mem_funct3  out  3  to DataMemory funct3
- mem_addr  out  ALEN  to DataMemory Address
- mem_wdata  out  XLEN  to DataMemory WriteData
- mem_rdata  in  XLEN  from DataMemory ReadData

## Operation

- Per-cycle grant decision, in priority order:
  - lock_owner valid → only that port may be granted.
  - Else starve_cnt == STARVE_MAX and p1_req → grant port 1.
  - Else p0_req → grant port 0.
  - Else p1_req → grant port 1.
  - At most one gnt per cycle.
- Mux: granted port's we/be/funct3/addr/wdata drive mem_*. mem_we = granted port's we.
- With no grant: mem_we=0, mem_be=0, mem_funct3=F3_WORD, mem_addr=0, mem_wdata=0.
- Stores complete in the grant cycle; no rvalid is generated.
- Loads: on grant, set rd_pending=1 and rd_owner=N. The next cycle, pN_rvalid=1 and pN_rdata=mem_rdata. Loads are fully pipelined, one per cycle back-to-back.
- pN_rdata is driven only toward rd_owner; the other port's rdata=0.
- Starvation counter starve_cnt (4 bits):
  - Increments when port 0 is granted while p1_req=1.
  - Clears when port 1 is granted, or when p1_req=0.
  - Saturates at STARVE_MAX.
- Lock FSM, states UNLOCKED, LOCKED0, LOCKED1:
  - UNLOCKED→LOCKEDN when port N is granted with pN_lock=1.
  - LOCKEDN→UNLOCKED on the first cycle pN_req=1 and pN_lock=0; that access is still granted.
  - LOCKEDN→UNLOCKED also if pN_req=0 and pN_lock=0.
  - While locked, the starvation override is suppressed and starve_cnt holds.
- Requesters hold req and all request fields stable until gnt. The arbiter does not buffer requests.

## Timing

- Grant: combinational, same cycle as req.
- Store commit: at the clk edge ending the grant cycle.
- Load data: pN_rvalid asserts exactly 1 cycle after the grant cycle, for 1 cycle.
- Reset (async, immediate) values:
  - pN_gnt=0, pN_rvalid=0, pN_rdata=0.
  - mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, mem_funct3=F3_WORD.
  - rd_pending=0, starve_cnt=0, lock FSM=UNLOCKED.
- Grant outputs are forced 0 while rst=1.
- Reset asserted mid-load: the pending rvalid is dropped and never asserted.
- Simultaneous requests: a new grant and an rvalid for the previous load can occur in the same cycle. A port may receive rvalid and gnt together.
- A load and a store to the same address in consecutive cycles: the load returns the pre-store word, since DataMemory's read is registered before the write takes effect.
- MMIO addresses (LED, tohost) pass through unchanged. The arbiter applies no address decode.

## Test plan

- p0 load addr 0x100 (RAM word 0xDEADBEEF), p1 idle → p0_gnt same cycle, p0_rvalid next cycle with p0_rdata=0xDEADBEEF, p1_rvalid=0.
- p0_req and p1_req held high with STARVE_MAX=4 → grant sequence 0,0,0,0,1,0,0,0,0,1; starve_cnt returns to 0 after each port-1 grant.
- p1 store 0x0000000A to 0x80000000, then p0 LW from 0x80000000 → LEDs=0xA; p0_rdata=0x0000000A one cycle after grant.
- p0 LB/LBU sequence with lock: p0_lock=1 on the load, p1_req held high → p1_gnt=0 until the p0 store with lock=0 is granted; p1 is granted the next cycle.
- Back-to-back loads p0 0x0, p1 0x4, p0 0x8 in three cycles → rvalid on p0, p1, p0 in the following three cycles with the correct words and no cross-routing.
- Assert rst in the cycle after a p1 load grant → p1_rvalid never asserts; all outputs at reset values immediately, before the next edge.
